// File: rtl/risc_z_pkg.sv
// Shared RISC-Z core definitions: datapath widths, reset fetch address, fetch FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package risc_z_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    // IDLE : nothing outstanding, buffer empty
    // FETCH: read request in flight, its data will be kept
    // DRAIN: read request in flight, its data will be thrown away
    // FULL : instruction buffer holds a word for decode
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the fetch address, reads imem via req/ack, buffers one word for decode.
// Latency: request to ir_valid is ack latency + 1 cycle; at best one instruction every 2 cycles.
// Backpressure: ir_ready=0 holds the word in the buffer and stops new requests; enable=0 only blocks new requests.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   enable                      global run; gates issuing of new memory requests
//   mem_req/mem_addr            instruction memory request, held stable until mem_ack
//   mem_ack/mem_rdata           memory completion and read data
//   ir_valid/ir/ir_pc/ir_ready  single-entry buffer towards decode
//   redirect/redirect_pc        taken branch/jump, one-cycle pulse
//   pc_en/pc_next               load pulse and value for the architectural PC register
module instr_fetch #(
    parameter int                ADDR_W   = risc_z_pkg::ADDR_W,
    parameter int                DATA_W   = risc_z_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = risc_z_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_valid,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              pc_en,
    output logic [ADDR_W-1:0] pc_next
);

    import risc_z_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] fetch_addr, fetch_addr_nxt;
    logic              mem_req_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              ir_valid_nxt;
    logic [DATA_W-1:0] ir_nxt;
    logic [ADDR_W-1:0] ir_pc_nxt;
    logic              pc_en_nxt;
    logic [ADDR_W-1:0] pc_next_nxt;

    // Sequential address after the word currently being fetched; wraps at 2^ADDR_W.
    logic [ADDR_W-1:0] seq_addr;
    assign seq_addr = mem_addr + ADDR_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            fetch_addr <= RESET_PC;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_PC;
            ir_valid   <= 1'b0;
            ir         <= '0;
            ir_pc      <= '0;
            pc_en      <= 1'b0;
            pc_next    <= RESET_PC;
        end else begin
            state      <= state_nxt;
            fetch_addr <= fetch_addr_nxt;
            mem_req    <= mem_req_nxt;
            mem_addr   <= mem_addr_nxt;
            ir_valid   <= ir_valid_nxt;
            ir         <= ir_nxt;
            ir_pc      <= ir_pc_nxt;
            pc_en      <= pc_en_nxt;
            pc_next    <= pc_next_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        fetch_addr_nxt = fetch_addr;
        mem_req_nxt    = mem_req;
        mem_addr_nxt   = mem_addr;
        ir_valid_nxt   = ir_valid;
        ir_nxt         = ir;
        ir_pc_nxt      = ir_pc;
        pc_en_nxt      = 1'b0;
        pc_next_nxt    = pc_next;

        case (state)
            IDLE: begin
                // A stray mem_ack here (e.g. left over from before reset) is ignored.
                if (enable) begin
                    mem_req_nxt  = 1'b1;
                    mem_addr_nxt = fetch_addr;
                    state_nxt    = FETCH;
                end
            end

            FETCH: begin
                if (mem_ack) begin
                    ir_nxt         = mem_rdata;
                    ir_pc_nxt      = mem_addr;
                    ir_valid_nxt   = 1'b1;
                    mem_req_nxt    = 1'b0;
                    fetch_addr_nxt = seq_addr;
                    pc_next_nxt    = seq_addr;
                    pc_en_nxt      = 1'b1;
                    state_nxt      = FULL;
                end
            end

            FULL: begin
                if (ir_ready) begin
                    ir_valid_nxt = 1'b0;
                    if (enable) begin
                        // Back-to-back: next request goes out on the same edge the word is taken.
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = fetch_addr;
                        state_nxt    = FETCH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            DRAIN: begin
                // Data of the abandoned request is dropped; fetch resumes at the redirect target.
                if (mem_ack) begin
                    if (enable) begin
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = fetch_addr;
                        state_nxt    = FETCH;
                    end else begin
                        mem_req_nxt = 1'b0;
                        state_nxt   = IDLE;
                    end
                end
            end

            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase

        // Redirect overrides everything above. A memory request already on the bus is
        // never withdrawn: it is allowed to complete in DRAIN and its data discarded.
        if (redirect) begin
            fetch_addr_nxt = redirect_pc;
            pc_next_nxt    = redirect_pc;
            pc_en_nxt      = 1'b1;
            ir_valid_nxt   = 1'b0;
            ir_nxt         = ir;
            ir_pc_nxt      = ir_pc;

            case (state)
                FETCH, DRAIN: begin
                    if (mem_ack) begin
                        if (state == DRAIN && enable) begin
                            mem_req_nxt  = 1'b1;
                            mem_addr_nxt = redirect_pc;
                            state_nxt    = FETCH;
                        end else begin
                            mem_req_nxt  = 1'b0;
                            mem_addr_nxt = mem_addr;
                            state_nxt    = IDLE;
                        end
                    end else begin
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = mem_addr;
                        state_nxt    = DRAIN;
                    end
                end
                default: begin
                    mem_req_nxt  = 1'b0;
                    mem_addr_nxt = mem_addr;
                    state_nxt    = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch with a latency-programmable instruction memory model.
// Latency: n/a.
// Backpressure: decode ready driven per scenario.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        pc_en;
    logic [15:0] pc_next;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_en       (pc_en),
        .pc_next     (pc_next)
    );

    // Memory model: acks a request after ack_lat cycles, data = 16'hA000 + address.
    bit          auto_ack    = 1'b0;
    bit   [15:0] model_rdata = 16'h0;
    bit          was_req     = 1'b0;
    int          age         = 0;
    int          ack_lat     = 2;
    bit          mem_en      = 1'b1;
    bit          force_ack   = 1'b0;
    bit   [15:0] force_rdata = 16'h0;

    assign mem_ack   = auto_ack | force_ack;
    assign mem_rdata = force_ack ? force_rdata : model_rdata;

    always @(posedge clk) begin
        #2;
        if (!mem_req || !mem_en) begin
            age      = 0;
            auto_ack = 1'b0;
        end else begin
            if (auto_ack || !was_req) age = 0;
            else age = age + 1;
            auto_ack    = (age >= ack_lat);
            model_rdata = 16'hA000 + mem_addr;
        end
        was_req = mem_req;
    end

    // Scoreboard queues
    logic [15:0] exp_addr[$];
    logic [15:0] exp_pc[$];
    logic [31:0] exp_ir[$];   // {ir, ir_pc}

    int checks = 0;
    int errors = 0;

    // Compare events visible at this negedge, then advance one clock.
    task automatic step();
        logic [15:0] ea;
        logic [31:0] ei;
        if (mem_req && mem_ack) begin
            checks++;
            if (exp_addr.size() == 0) begin
                errors++;
                $display("FAIL ack_addr: unexpected ack at addr %h, none expected", mem_addr);
            end else begin
                ea = exp_addr.pop_front();
                if (mem_addr !== ea) begin
                    errors++;
                    $display("FAIL ack_addr: got %h expected %h", mem_addr, ea);
                end
            end
        end
        if (ir_valid && ir_ready && !redirect) begin
            checks++;
            if (exp_ir.size() == 0) begin
                errors++;
                $display("FAIL deliver: unexpected ir=%h ir_pc=%h", ir, ir_pc);
            end else begin
                ei = exp_ir.pop_front();
                if ({ir, ir_pc} !== ei) begin
                    errors++;
                    $display("FAIL deliver: got ir=%h ir_pc=%h expected ir=%h ir_pc=%h",
                             ir, ir_pc, ei[31:16], ei[15:0]);
                end
            end
        end
        if (pc_en) begin
            checks++;
            if (exp_pc.size() == 0) begin
                errors++;
                $display("FAIL pc_en: unexpected pulse pc_next=%h", pc_next);
            end else begin
                ea = exp_pc.pop_front();
                if (pc_next !== ea) begin
                    errors++;
                    $display("FAIL pc_next: got %h expected %h", pc_next, ea);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (ir_valid) break;
            step();
        end
        checks++;
        if (ir_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_valid: ir_valid=%b after %0d cycles, expected 1", ir_valid, budget);
        end
    endtask

    // Wait for a word, then accept it; stop=1 drops enable so fetch parks in IDLE.
    task automatic deliver_one(input bit stop);
        ir_ready = 1'b0;
        wait_valid(50);
        if (stop) enable = 1'b0;
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
    endtask

    task automatic finish_test(input string name);
        checks++;
        if (exp_addr.size() != 0 || exp_pc.size() != 0 || exp_ir.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: addr=%0d pc=%0d ir=%0d pending, expected 0/0/0",
                     name, exp_addr.size(), exp_pc.size(), exp_ir.size());
        end
        exp_addr.delete();
        exp_pc.delete();
        exp_ir.delete();
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (mem_req !== 1'b0 || mem_addr !== 16'h0 || ir_valid !== 1'b0 || ir !== 16'h0 ||
            ir_pc !== 16'h0 || pc_en !== 1'b0 || pc_next !== 16'h0) begin
            errors++;
            $display("FAIL %s: req=%b addr=%h v=%b ir=%h ir_pc=%h pc_en=%b pc_next=%h, expected all 0",
                     name, mem_req, mem_addr, ir_valid, ir, ir_pc, pc_en, pc_next);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        @(negedge clk);
        step(); step();
        check_reset_values("reset_values");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL enable_low_idle: mem_req=%b expected 0", mem_req);
            end
        end
        finish_test("reset");
    endtask

    task automatic test_stream();
        ack_lat = 2;
        for (int a = 0; a < 3; a++) begin
            exp_addr.push_back(16'(a));
            exp_pc.push_back(16'(a + 1));
            exp_ir.push_back({16'hA000 + 16'(a), 16'(a)});
        end
        enable = 1'b1;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h expected 1 0000", mem_req, mem_addr);
        end
        deliver_one(1'b0);
        deliver_one(1'b0);
        deliver_one(1'b1);
        finish_test("stream");
    endtask

    task automatic test_stall();
        enable = 1'b1;
        exp_addr.push_back(16'h0003);
        exp_pc.push_back(16'h0004);
        wait_valid(50);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ir_valid !== 1'b1 || ir !== 16'hA003 || ir_pc !== 16'h0003 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: v=%b ir=%h ir_pc=%h req=%b expected 1 A003 0003 0",
                         ir_valid, ir, ir_pc, mem_req);
            end
            step();
        end
        exp_ir.push_back({16'hA003, 16'h0003});
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0004 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: req=%b addr=%h v=%b expected 1 0004 0", mem_req, mem_addr, ir_valid);
        end
        exp_addr.push_back(16'h0004);
        exp_pc.push_back(16'h0005);
        exp_ir.push_back({16'hA004, 16'h0004});
        deliver_one(1'b1);
        finish_test("stall");
    endtask

    task automatic test_redirect_pending();
        ack_lat = 3;
        enable = 1'b1;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0005 || mem_ack !== 1'b0) begin
            errors++;
            $display("FAIL redir_pre: req=%b addr=%h ack=%b expected 1 0005 0", mem_req, mem_addr, mem_ack);
        end
        redirect = 1'b1; redirect_pc = 16'h0040;
        exp_pc.push_back(16'h0040);
        exp_addr.push_back(16'h0005);
        step();
        redirect = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0005 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_hold: req=%b addr=%h v=%b expected 1 0005 0", mem_req, mem_addr, ir_valid);
        end
        exp_addr.push_back(16'h0040);
        exp_pc.push_back(16'h0041);
        exp_ir.push_back({16'hA040, 16'h0040});
        deliver_one(1'b1);
        finish_test("redirect_pending");
    endtask

    task automatic test_redirect_ack();
        ack_lat = 0;
        enable = 1'b1;
        redirect_pc = 16'h0080;
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0041 || mem_ack !== 1'b1) begin
            errors++;
            $display("FAIL redir_ack_pre: req=%b addr=%h ack=%b expected 1 0041 1", mem_req, mem_addr, mem_ack);
        end
        redirect = 1'b1;
        exp_addr.push_back(16'h0041);
        exp_pc.push_back(16'h0080);
        step();
        redirect = 1'b0;
        checks++;
        if (ir_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_ack_drop: v=%b req=%b expected 0 0", ir_valid, mem_req);
        end
        exp_addr.push_back(16'h0080);
        exp_pc.push_back(16'h0081);
        exp_ir.push_back({16'hA080, 16'h0080});
        deliver_one(1'b1);
        finish_test("redirect_ack");
    endtask

    task automatic test_back_to_back();
        int n    = 0;
        int cyc  = 0;
        int last = 0;
        ack_lat = 0;
        for (int a = 16'h81; a <= 16'h84; a++) begin
            exp_addr.push_back(16'(a));
            exp_pc.push_back(16'(a + 1));
            exp_ir.push_back({16'hA000 + 16'(a), 16'(a)});
        end
        enable = 1'b1;
        ir_ready = 1'b1;
        for (int i = 0; i < 40 && n < 4; i++) begin
            if (ir_valid && ir_ready && !redirect) begin
                if (n > 0) begin
                    checks++;
                    if (cyc - last != 2) begin
                        errors++;
                        $display("FAIL b2b_gap: %0d cycles between words, expected 2", cyc - last);
                    end
                end
                last = cyc;
                n++;
            end
            step();
            cyc++;
            if (n == 3) enable = 1'b0;
        end
        ir_ready = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL b2b_count: %0d words delivered, expected 4", n);
        end
        step();
        finish_test("back_to_back");
    endtask

    task automatic test_wrap();
        enable = 1'b0;
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        exp_pc.push_back(16'hFFFF);
        exp_pc.push_back(16'h0000);
        exp_addr.push_back(16'hFFFF);
        exp_ir.push_back({16'h9FFF, 16'hFFFF});
        step();
        redirect = 1'b0;
        ack_lat = 1;
        enable = 1'b1;
        deliver_one(1'b0);
        ack_lat = 20;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_next: req=%b addr=%h expected 1 0000", mem_req, mem_addr);
        end
        finish_test("wrap");
    endtask

    task automatic test_reset_midfetch();
        mem_en = 1'b0;
        reset = 1'b1;
        step(); step();
        check_reset_values("midfetch_reset");
        reset = 1'b0;
        enable = 1'b0;
        force_rdata = 16'hBEEF;
        force_ack = 1'b1;
        step(); step();
        force_ack = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || ir_valid !== 1'b0 || ir !== 16'h0 || pc_next !== 16'h0) begin
            errors++;
            $display("FAIL stray_ack: req=%b v=%b ir=%h pc_next=%h expected 0 0 0000 0000",
                     mem_req, ir_valid, ir, pc_next);
        end
        mem_en = 1'b1;
        ack_lat = 1;
        enable = 1'b1;
        exp_addr.push_back(16'h0000);
        exp_pc.push_back(16'h0001);
        exp_ir.push_back({16'hA000, 16'h0000});
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset_req: req=%b addr=%h expected 1 0000", mem_req, mem_addr);
        end
        deliver_one(1'b1);
        finish_test("reset_midfetch");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_pending();
        test_redirect_ack();
        test_back_to_back();
        test_wrap();
        test_reset_midfetch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
